// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: stall vectors,
// multi-cycle sequencer states and stall-cause encoding.
package pipe_stall_ctrl_pkg;

  localparam int unsigned STALL_W = 6;

  // stall vector bit order: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1 = stop
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_IF   = 3'd1,
    CAUSE_ID   = 3'd2,
    CAUSE_EX   = 3'd3,
    CAUSE_MEM  = 3'd4
  } stall_cause_e;

  function automatic logic [STALL_W-1:0] stall_code(input stall_cause_e cause);
    case (cause)
      CAUSE_IF:  return STALL_IF;
      CAUSE_ID:  return STALL_ID;
      CAUSE_EX:  return STALL_EX;
      CAUSE_MEM: return STALL_MEM;
      default:   return STALL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_ex_mc_seq.sv
// EX multi-cycle sequencer: freezes EX for max(len,1) cycles after start,
// then pulses done for one cycle. cancel abandons the sequence silently.
module pipe_stall_ctrl_ex_mc_seq
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MC_LEN_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [MC_LEN_W-1:0] len,
  input  logic                cancel,
  output logic                busy,
  output logic                done,
  output logic                stall_req
);

  mc_state_e           state;
  logic [MC_LEN_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || cancel) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MC_IDLE: begin
          if (start) begin
            state <= MC_BUSY;
            cnt   <= (len == '0) ? '0 : len - MC_LEN_W'(1);
          end
        end
        MC_BUSY: begin
          if (cnt == '0) state <= MC_IDLE;
          else           cnt   <= cnt - MC_LEN_W'(1);
        end
        default: state <= MC_IDLE;
      endcase
    end
  end

  // the start cycle itself is the first stalled cycle
  assign busy      = (state == MC_BUSY);
  assign done      = busy && (cnt == '0) && !cancel;
  assign stall_req = !cancel && (((state == MC_IDLE) && start) || (busy && (cnt != '0)));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller: stall priority encoder, flush mux, stall
// watchdog and EX multi-cycle sequencer. STALL_PERF_EN adds stall-cause counters.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 1024,
  parameter int unsigned MC_LEN_W    = 6,
  parameter int unsigned PERF_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_if_i,
  input  logic                stallreq_id_i,
  input  logic                stallreq_mem_i,
  input  logic                ex_mc_start_i,
  input  logic [MC_LEN_W-1:0] ex_mc_len_i,
  input  logic                flush_req_i,
  input  logic [31:0]         new_pc_i,
  output logic [5:0]          stall_o,
  output logic                flush_o,
  output logic [31:0]         new_pc_o,
  output logic                ex_mc_busy_o,
  output logic                ex_mc_done_o,
  output logic                wdog_o,
  input  logic [1:0]          perf_sel_i,
  output logic [PERF_W-1:0]   perf_cnt_o
);

  localparam int unsigned WDOG_CW = $clog2(WDOG_CYCLES + 1);

  logic         mc_busy;
  logic         mc_done;
  logic         mc_stall;
  stall_cause_e cause;

  pipe_stall_ctrl_ex_mc_seq #(
    .MC_LEN_W (MC_LEN_W)
  ) u_ex_mc_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (ex_mc_start_i),
    .len       (ex_mc_len_i),
    .cancel    (flush_req_i),
    .busy      (mc_busy),
    .done      (mc_done),
    .stall_req (mc_stall)
  );

  // deepest requester wins; flush overrides every stall
  always_comb begin
    cause    = CAUSE_NONE;
    flush_o  = 1'b0;
    new_pc_o = '0;
    if (!rst) begin
      if (flush_req_i) begin
        flush_o  = 1'b1;
        new_pc_o = new_pc_i;
      end else if (stallreq_mem_i) cause = CAUSE_MEM;
      else if (mc_stall)           cause = CAUSE_EX;
      else if (stallreq_id_i)      cause = CAUSE_ID;
      else if (stallreq_if_i)      cause = CAUSE_IF;
    end
  end

  assign stall_o      = stall_code(cause);
  assign ex_mc_busy_o = mc_busy && !rst;
  assign ex_mc_done_o = mc_done && !rst;

  // counts consecutive frozen-PC cycles; flag is sticky until reset
  logic [WDOG_CW-1:0] wdog_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
      wdog_o   <= 1'b0;
    end else if (!stall_o[0]) begin
      wdog_cnt <= '0;
    end else begin
      if (wdog_cnt != WDOG_CW'(WDOG_CYCLES)) wdog_cnt <= wdog_cnt + WDOG_CW'(1);
      if (wdog_cnt == WDOG_CW'(WDOG_CYCLES - 1)) wdog_o <= 1'b1;
    end
  end

`ifdef STALL_PERF_EN
  // index 0..3 maps to cause IF, ID, EX, MEM
  logic [PERF_W-1:0] perf_cnt [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) perf_cnt[i] <= '0;
      perf_cnt_o <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if ((cause == stall_cause_e'(3'(i + 1))) && (perf_cnt[i] != '1))
          perf_cnt[i] <= perf_cnt[i] + PERF_W'(1);
      end
      perf_cnt_o <= perf_cnt[perf_sel_i];
    end
  end
`else
  logic unused_perf_sel;
  assign unused_perf_sel = ^perf_sel_i;
  assign perf_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: each cycle's expected outputs are
// queued when inputs are driven and compared at the following negedge.
module tb_pipe_stall_ctrl;

  localparam int unsigned MC_LEN_W = 6;
  localparam int unsigned PERF_W   = 32;
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_IF   = 6'b000011;
  localparam logic [5:0] S_ID   = 6'b000111;
  localparam logic [5:0] S_EX   = 6'b001111;
  localparam logic [5:0] S_MEM  = 6'b011111;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic        done;
    logic        wdog;
  } obs_t;

  logic                clk;
  logic                rst;
  logic                stallreq_if_i, stallreq_id_i, stallreq_mem_i;
  logic                ex_mc_start_i;
  logic [MC_LEN_W-1:0] ex_mc_len_i;
  logic                flush_req_i;
  logic [31:0]         new_pc_i;
  logic [5:0]          stall_o;
  logic                flush_o;
  logic [31:0]         new_pc_o;
  logic                ex_mc_busy_o, ex_mc_done_o, wdog_o;
  logic [1:0]          perf_sel_i;
  logic [PERF_W-1:0]   perf_cnt_o;

  obs_t              sb[$];
  logic [PERF_W-1:0] perf_q[$];
  int                checks = 0;
  int                passes = 0;

  pipe_stall_ctrl #(
    .WDOG_CYCLES (8),
    .MC_LEN_W    (MC_LEN_W),
    .PERF_W      (PERF_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_if_i  (stallreq_if_i),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_mem_i (stallreq_mem_i),
    .ex_mc_start_i  (ex_mc_start_i),
    .ex_mc_len_i    (ex_mc_len_i),
    .flush_req_i    (flush_req_i),
    .new_pc_i       (new_pc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .ex_mc_busy_o   (ex_mc_busy_o),
    .ex_mc_done_o   (ex_mc_done_o),
    .wdog_o         (wdog_o),
    .perf_sel_i     (perf_sel_i),
    .perf_cnt_o     (perf_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic obs_t mk(input logic [5:0] s, input logic fl, input logic [31:0] pc,
                              input logic busy, input logic done, input logic wd);
    obs_t o;
    o.stall = s; o.flush = fl; o.pc = pc; o.busy = busy; o.done = done; o.wdog = wd;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(stall_o, flush_o, new_pc_o, ex_mc_busy_o, ex_mc_done_o, wdog_o);
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("stall=%b flush=%b pc=%h busy=%b done=%b wdog=%b",
                     o.stall, o.flush, o.pc, o.busy, o.done, o.wdog);
  endfunction

  task automatic drive(input logic r, input logic fi, input logic fid, input logic fm,
                       input logic st, input logic [5:0] ln, input logic fl,
                       input logic [31:0] pc, input obs_t e);
    @(posedge clk); #1;
    rst = r; stallreq_if_i = fi; stallreq_id_i = fid; stallreq_mem_i = fm;
    ex_mc_start_i = st; ex_mc_len_i = ln; flush_req_i = fl; new_pc_i = pc;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; stallreq_if_i = 1'b0; stallreq_id_i = 1'b0; stallreq_mem_i = 1'b0;
    ex_mc_start_i = 1'b0; ex_mc_len_i = '0; flush_req_i = 1'b0; new_pc_i = '0; perf_sel_i = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, want;
    for (int c = 0; c < 14; c++) begin
      if (c < 2)      drive(0, 0, 0, 0, c == 0, 6'd10, 0, 32'h0, mk(S_EX, 0, 0, c == 1, 0, 0));
      else if (c < 4) drive(1, 1, 1, 1, 1, 6'd3, 1, 32'h1234, mk(S_NONE, 0, 0, 0, 0, 0));
      else            drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0, mk(S_NONE, 0, 0, 0, 0, 0));
      @(negedge clk); got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL reset c%0d: got %s want %s", c, fmt(got), fmt(want));
      else passes++;
    end
  endtask

  task automatic test_id_stall();
    obs_t got, want;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, c < 3, 0, 0, 6'd0, 0, 32'h0, mk(c < 3 ? S_ID : S_NONE, 0, 0, 0, 0, 0));
      @(negedge clk); got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL id_stall c%0d: got %s want %s", c, fmt(got), fmt(want));
      else passes++;
    end
  endtask

  task automatic test_mc_len5();
    obs_t got, want;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(0, 0, 0, 0, c == 0, 6'd5, 0, 32'h0,
            mk(c < 5 ? S_EX : S_NONE, 0, 0, c >= 1 && c <= 5, c == 5, 0));
      @(negedge clk); got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL mc_len5 c%0d: got %s want %s", c, fmt(got), fmt(want));
      else passes++;
    end
  endtask

  task automatic test_mc_mem();
    obs_t got, want;
    logic [5:0] s;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      s = (c <= 1) ? S_EX : (c <= 7) ? S_MEM : S_NONE;
      drive(0, 0, 0, c >= 2 && c <= 7, c == 0, 6'd5, 0, 32'h0,
            mk(s, 0, 0, c >= 1 && c <= 5, c == 5, c >= 8));
      @(negedge clk); got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL mc_mem c%0d: got %s want %s", c, fmt(got), fmt(want));
      else passes++;
    end
  endtask

  task automatic test_flush();
    obs_t got, want;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      drive(0, 0, 0, 0, c == 0, 6'd10, c == 3, (c == 2 || c == 3) ? 32'h20 : 32'h0,
            mk(c < 3 ? S_EX : S_NONE, c == 3, c == 3 ? 32'h20 : 32'h0, c >= 1 && c <= 3, 0, 0));
      @(negedge clk); got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL flush c%0d: got %s want %s", c, fmt(got), fmt(want));
      else passes++;
    end
  endtask

  task automatic test_len_bounds();
    obs_t got, want;
    for (int l = 0; l < 2; l++) begin
      do_reset();
      for (int c = 0; c < 3; c++) begin
        drive(0, 0, 0, 0, c == 0, 6'(l), 0, 32'h0,
              mk(c == 0 ? S_EX : S_NONE, 0, 0, c == 1, c == 1, 0));
        @(negedge clk); got = sample(); want = sb.pop_front(); checks++;
        if (got !== want) $display("FAIL len%0d c%0d: got %s want %s", l, c, fmt(got), fmt(want));
        else passes++;
      end
    end
    do_reset();
    for (int c = 0; c < 65; c++) begin
      drive(0, 0, 0, 0, c == 0, 6'd63, 0, 32'h0,
            mk(c < 63 ? S_EX : S_NONE, 0, 0, c >= 1 && c <= 63, c == 63, c >= 8));
      @(negedge clk); got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL len63 c%0d: got %s want %s", c, fmt(got), fmt(want));
      else passes++;
    end
  endtask

  task automatic test_start_while_busy();
    obs_t got, want;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: drive(0, 0, 0, 0, 1, 6'd3,  0, 32'h0,  mk(S_EX,   0, 0,      0, 0, 0));
        1: drive(0, 0, 0, 0, 1, 6'd10, 0, 32'h0,  mk(S_EX,   0, 0,      1, 0, 0));
        2: drive(0, 0, 0, 0, 0, 6'd0,  0, 32'h0,  mk(S_EX,   0, 0,      1, 0, 0));
        3: drive(0, 0, 0, 0, 0, 6'd0,  0, 32'h0,  mk(S_NONE, 0, 0,      1, 1, 0));
        4: drive(0, 0, 0, 0, 0, 6'd0,  0, 32'h0,  mk(S_NONE, 0, 0,      0, 0, 0));
        5: drive(0, 0, 0, 0, 1, 6'd4,  1, 32'h40, mk(S_NONE, 1, 32'h40, 0, 0, 0));
        default: drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0, mk(S_NONE, 0, 0, 0, 0, 0));
      endcase
      @(negedge clk); got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL start_busy c%0d: got %s want %s", c, fmt(got), fmt(want));
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, want;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(0, 0, 0, 0, c == 0 || c == 2 || c == 3, 6'd2, 0, 32'h0,
            mk((c <= 1 || c == 3 || c == 4) ? S_EX : S_NONE, 0, 0,
               c == 1 || c == 2 || c == 4 || c == 5, c == 2 || c == 5, 0));
      @(negedge clk); got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL back_to_back c%0d: got %s want %s", c, fmt(got), fmt(want));
      else passes++;
    end
  endtask

  task automatic test_priority();
    obs_t got, want;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: drive(0, 1, 0, 0, 0, 6'd0, 0, 32'h0,   mk(S_IF,   0, 0,       0, 0, 0));
        1: drive(0, 1, 1, 0, 0, 6'd0, 0, 32'h0,   mk(S_ID,   0, 0,       0, 0, 0));
        2: drive(0, 1, 1, 1, 0, 6'd0, 0, 32'h0,   mk(S_MEM,  0, 0,       0, 0, 0));
        3: drive(0, 1, 1, 0, 1, 6'd1, 0, 32'h0,   mk(S_EX,   0, 0,       0, 0, 0));
        4: drive(0, 1, 1, 0, 0, 6'd0, 0, 32'h0,   mk(S_ID,   0, 0,       1, 1, 0));
        5: drive(0, 1, 1, 1, 1, 6'd5, 1, 32'h100, mk(S_NONE, 1, 32'h100, 0, 0, 0));
        default: drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0, mk(S_NONE, 0, 0, 0, 0, 0));
      endcase
      @(negedge clk); got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL priority c%0d: got %s want %s", c, fmt(got), fmt(want));
      else passes++;
    end
  endtask

  task automatic test_watchdog();
    obs_t got, want;
    logic fi;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      fi = (c <= 6) || (c >= 8 && c <= 15) || (c == 19);
      drive(0, fi, 0, 0, 0, 6'd0, 0, 32'h0, mk(fi ? S_IF : S_NONE, 0, 0, 0, 0, c >= 16));
      @(negedge clk); got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL watchdog c%0d: got %s want %s", c, fmt(got), fmt(want));
      else passes++;
    end
    do_reset();
    drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0, mk(S_NONE, 0, 0, 0, 0, 0));
    @(negedge clk); got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) $display("FAIL watchdog_clear: got %s want %s", fmt(got), fmt(want));
    else passes++;
  endtask

  task automatic test_perf();
    obs_t got, want;
    logic [PERF_W-1:0] pwant;
    int pe [8];
    int ps [8];
`ifdef STALL_PERF_EN
    pe = '{0, 0, 1, 2, 3, 4, 0, 4};
`else
    pe = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
    ps = '{1, 1, 1, 1, 1, 0, 1, 1};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, c < 4, 0, 0, 6'd0, 0, 32'h0, mk(c < 4 ? S_ID : S_NONE, 0, 0, 0, 0, 0));
      perf_sel_i = 2'(ps[c]);
      perf_q.push_back(PERF_W'(pe[c]));
      @(negedge clk); got = sample(); want = sb.pop_front(); pwant = perf_q.pop_front();
      checks++;
      if (got !== want) $display("FAIL perf_stall c%0d: got %s want %s", c, fmt(got), fmt(want));
      else passes++;
      checks++;
      if (perf_cnt_o !== pwant) $display("FAIL perf_cnt c%0d: got %0d want %0d", c, perf_cnt_o, pwant);
      else passes++;
    end
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0, mk(S_NONE, 0, 0, 0, 0, 0));
      perf_sel_i = 2'd1;
      perf_q.push_back('0);
      @(negedge clk); pwant = perf_q.pop_front(); void'(sb.pop_front());
      checks++;
      if (perf_cnt_o !== pwant) $display("FAIL perf_reset c%0d: got %0d want %0d", c, perf_cnt_o, pwant);
      else passes++;
    end
  endtask

  initial begin
    rst = 1'b1; stallreq_if_i = 1'b0; stallreq_id_i = 1'b0; stallreq_mem_i = 1'b0;
    ex_mc_start_i = 1'b0; ex_mc_len_i = '0; flush_req_i = 1'b0; new_pc_i = '0; perf_sel_i = '0;
    test_reset();
    test_id_stall();
    test_mc_len5();
    test_mc_mem();
    test_flush();
    test_len_bounds();
    test_start_while_busy();
    test_back_to_back();
    test_priority();
    test_watchdog();
    test_perf();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
